// File: rtl/imem_prog_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_prog_loader_pkg;

   localparam int BYTE_W = 8;
   localparam int LEN_W  = 16;
   localparam int WORD_W = 32;
   localparam int IDX_W  = 16;

   localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN0  = 3'd1,
      ST_LEN1  = 3'd2,
      ST_DATA  = 3'd3,
      ST_WRITE = 3'd4,
      ST_CSUM  = 3'd5,
      ST_RUN   = 3'd6,
      ST_ERR   = 3'd7
   } loader_state_t;

   // Byte address of instruction word idx, modulo 2^32.
   function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] base,
                                                   input logic [IDX_W-1:0]  idx);
      return base + {14'b00_0000_0000_0000, idx, 2'b00};
   endfunction

endpackage

// File: rtl/imem_prog_loader_if.sv
// Byte-stream input and instruction-memory programming bus of the loader.
interface imem_prog_loader_if;
   import imem_prog_loader_pkg::*;

   logic              rx_valid;
   logic [BYTE_W-1:0] rx_data;
   logic              rx_ready;
   logic [WORD_W-1:0] tb_addr;
   logic [WORD_W-1:0] tb_inst;
   logic              tb_we;
   logic              cpu_reset_n;
   logic              done;
   logic              err;

   // Loader side.
   modport slave (
      input  rx_valid, rx_data,
      output rx_ready, tb_addr, tb_inst, tb_we, cpu_reset_n, done, err
   );

   // Byte source / observer side.
   modport master (
      output rx_valid, rx_data,
      input  rx_ready, tb_addr, tb_inst, tb_we, cpu_reset_n, done, err
   );
endinterface

// File: rtl/imem_prog_loader_timeout.sv
// Inter-byte idle counter; expire pulses on the idle cycle that completes
// TIMEOUT_CYC cycles without an accepted byte.
module imem_prog_loader_timeout #(
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);
   localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_r;

   // Count idle cycles; an accepted byte restarts, disabled states hold the count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r <= '0;
      end else if (clear) begin
         cnt_r <= '0;
      end else if (enable) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Flag the idle cycle that reaches the timeout.
   always_comb begin
      expire = 1'b0;
      if (enable && !clear && (cnt_r == LAST_CNT)) begin
         expire = 1'b1;
      end else begin
         expire = 1'b0;
      end
   end
endmodule

// File: rtl/imem_prog_loader.sv
// Framed byte-stream loader for the core's instruction memory: assembles
// little-endian words, writes them sequentially, verifies an XOR checksum
// and holds the core in reset until a frame completes cleanly.
module imem_prog_loader
   import imem_prog_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          MAX_WORDS   = 256,
   parameter int          TIMEOUT_CYC = 1000000
) (
   input  logic              clk,
   input  logic              reset,
   imem_prog_loader_if.slave bus
);
   localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(MAX_WORDS);

   loader_state_t     state_r;
   logic [LEN_W-1:0]  len_r;
   logic [IDX_W-1:0]  idx_r;
   logic [1:0]        byte_cnt_r;
   logic [WORD_W-1:0] shift_r;
   logic [BYTE_W-1:0] csum_r;
   logic [WORD_W-1:0] tb_addr_r;
   logic [WORD_W-1:0] tb_inst_r;
   logic              tb_we_r;
   logic              cpu_reset_n_r;
   logic              done_r;
   logic              err_r;
   logic              rx_ready_r;

   logic              accept_s;
   logic              tmo_en_s;
   logic              expire_s;
   logic [LEN_W-1:0]  len_full_s;

   assign accept_s   = bus.rx_valid & rx_ready_r;
   assign len_full_s = {bus.rx_data, len_r[BYTE_W-1:0]};

   // Idle timeout runs only while a frame is being received.
   always_comb begin
      tmo_en_s = 1'b0;
      case (state_r)
         ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM: tmo_en_s = 1'b1;
         default:                            tmo_en_s = 1'b0;
      endcase
   end

   imem_prog_loader_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (accept_s),
      .enable (tmo_en_s),
      .expire (expire_s)
   );

   // Frame FSM with word assembly, running checksum and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         len_r         <= 16'h0000;
         idx_r         <= 16'h0000;
         byte_cnt_r    <= 2'd0;
         shift_r       <= 32'h0000_0000;
         csum_r        <= 8'h00;
         tb_addr_r     <= BASE_ADDR;
         tb_inst_r     <= 32'h0000_0000;
         tb_we_r       <= 1'b0;
         cpu_reset_n_r <= 1'b0;
         done_r        <= 1'b0;
         err_r         <= 1'b0;
         rx_ready_r    <= 1'b1;
      end else begin
         tb_we_r <= 1'b0;
         case (state_r)
            ST_IDLE, ST_RUN, ST_ERR: begin
               // A sync byte (re)starts a frame; anything else is dropped.
               if (accept_s && (bus.rx_data == SYNC_BYTE)) begin
                  state_r       <= ST_LEN0;
                  csum_r        <= 8'h00;
                  idx_r         <= 16'h0000;
                  byte_cnt_r    <= 2'd0;
                  cpu_reset_n_r <= 1'b0;
                  done_r        <= 1'b0;
                  err_r         <= 1'b0;
               end else begin
                  state_r <= state_r;
               end
            end
            ST_LEN0: begin
               if (accept_s) begin
                  len_r   <= {8'h00, bus.rx_data};
                  csum_r  <= csum_r ^ bus.rx_data;
                  state_r <= ST_LEN1;
               end else if (expire_s) begin
                  state_r <= ST_ERR;
                  err_r   <= 1'b1;
               end else begin
                  state_r <= ST_LEN0;
               end
            end
            ST_LEN1: begin
               if (accept_s) begin
                  len_r  <= len_full_s;
                  csum_r <= csum_r ^ bus.rx_data;
                  if ({1'b0, len_full_s} > MAX_LEN) begin
                     state_r <= ST_ERR;
                     err_r   <= 1'b1;
                  end else if (len_full_s == 16'h0000) begin
                     state_r <= ST_CSUM;
                  end else begin
                     state_r <= ST_DATA;
                  end
               end else if (expire_s) begin
                  state_r <= ST_ERR;
                  err_r   <= 1'b1;
               end else begin
                  state_r <= ST_LEN1;
               end
            end
            ST_DATA: begin
               // Bytes arrive LSB first, so shift in from the top.
               if (accept_s) begin
                  shift_r    <= {bus.rx_data, shift_r[WORD_W-1:BYTE_W]};
                  csum_r     <= csum_r ^ bus.rx_data;
                  byte_cnt_r <= byte_cnt_r + 2'd1;
                  if (byte_cnt_r == 2'd3) begin
                     state_r    <= ST_WRITE;
                     rx_ready_r <= 1'b0;
                  end else begin
                     state_r <= ST_DATA;
                  end
               end else if (expire_s) begin
                  state_r <= ST_ERR;
                  err_r   <= 1'b1;
               end else begin
                  state_r <= ST_DATA;
               end
            end
            ST_WRITE: begin
               tb_we_r    <= 1'b1;
               tb_addr_r  <= word_addr(BASE_ADDR, idx_r);
               tb_inst_r  <= shift_r;
               idx_r      <= idx_r + 16'd1;
               rx_ready_r <= 1'b1;
               if ((idx_r + 16'd1) == len_r) begin
                  state_r <= ST_CSUM;
               end else begin
                  state_r <= ST_DATA;
               end
            end
            ST_CSUM: begin
               if (accept_s) begin
                  if (bus.rx_data == csum_r) begin
                     state_r       <= ST_RUN;
                     cpu_reset_n_r <= 1'b1;
                     done_r        <= 1'b1;
                  end else begin
                     state_r <= ST_ERR;
                     err_r   <= 1'b1;
                  end
               end else if (expire_s) begin
                  state_r <= ST_ERR;
                  err_r   <= 1'b1;
               end else begin
                  state_r <= ST_CSUM;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.rx_ready    = rx_ready_r;
   assign bus.tb_addr     = tb_addr_r;
   assign bus.tb_inst     = tb_inst_r;
   assign bus.tb_we       = tb_we_r;
   assign bus.cpu_reset_n = cpu_reset_n_r;
   assign bus.done        = done_r;
   assign bus.err         = err_r;
endmodule

// File: tb/tb_imem_prog_loader.sv
// Self-checking bench for imem_prog_loader: directed frames from the test
// plan plus randomized frames checked against a frame-level model.
module tb_imem_prog_loader;
   localparam logic [31:0] BASE   = 32'h0000_0000;
   localparam int          TB_MAX = 8;
   localparam int          TB_TMO = 16;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   imem_prog_loader_if bus();

   imem_prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(TB_MAX), .TIMEOUT_CYC(TB_TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          stall_cnt = 0;
   logic [7:0]  frame_q[$];
   logic [63:0] exp_wr_q[$];
   logic [63:0] wr_q[$];

   // Record every instruction-memory write strobe.
   always @(negedge clk) begin
      if (bus.tb_we === 1'b1) wr_q.push_back({bus.tb_addr, bus.tb_inst});
   end

   // Reference model: random frame of n words; expected writes are word i at BASE+4i.
   task automatic make_frame(input int n, input bit bad);
      logic [31:0] w;
      logic [15:0] n16;
      logic [7:0]  cs;
      n16 = 16'(n);
      frame_q.delete();
      exp_wr_q.delete();
      frame_q.push_back(8'hA5);
      frame_q.push_back(n16[7:0]);
      frame_q.push_back(n16[15:8]);
      for (int i = 0; i < n; i++) begin
         w = $urandom();
         exp_wr_q.push_back({BASE + 32'(4 * i), w});
         for (int b = 0; b < 4; b++) frame_q.push_back(w[8*b +: 8]);
      end
      cs = 8'h00;
      for (int i = 1; i < frame_q.size(); i++) cs = cs ^ frame_q[i];
      frame_q.push_back(bad ? ~cs : cs);
   endtask

   // Send frame_q; gaps inserts random idle cycles, otherwise rx_valid stays high.
   task automatic drive_frame(input bit gaps);
      int g;
      int guard;
      for (int i = 0; i < frame_q.size(); i++) begin
         if (gaps) begin
            g = $urandom_range(0, 2);
            if (g > 0) begin
               bus.rx_valid = 1'b0;
               repeat (g) @(negedge clk);
            end
         end
         bus.rx_valid = 1'b1;
         bus.rx_data  = frame_q[i];
         guard = 0;
         while (bus.rx_ready !== 1'b1 && guard < 8) begin
            stall_cnt++;
            @(negedge clk);
            guard++;
         end
         if (guard >= 8) begin
            n_cmp++; n_bad++;
            $display("FAIL rx_ready_stuck: byte %0d not accepted within 8 cycles", i);
         end
         @(negedge clk);
      end
      bus.rx_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.rx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rx_ready: got %b want 1", bus.rx_ready); end
      n_cmp++;
      if (bus.tb_addr !== BASE) begin n_bad++; $display("FAIL reset_tb_addr: got %h want %h", bus.tb_addr, BASE); end
      n_cmp++;
      if ({bus.tb_inst, bus.tb_we} !== 33'h0) begin n_bad++; $display("FAIL reset_tb_inst_we: got %h/%b want 0/0", bus.tb_inst, bus.tb_we); end
      n_cmp++;
      if ({bus.cpu_reset_n, bus.done, bus.err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {bus.cpu_reset_n, bus.done, bus.err}); end
   endtask

   task automatic test_good_frame(input logic [7:0] cs_byte, input logic [2:0] exp_flags, input string nm);
      frame_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, cs_byte};
      exp_wr_q = '{{32'h0000_0000, 32'h0010_0513}, {32'h0000_0004, 32'h0020_0593}};
      wr_q.delete();
      drive_frame(1'b0);
      n_cmp++;
      if (wr_q.size() !== exp_wr_q.size()) begin n_bad++; $display("FAIL %s_wr_count: got %0d want %0d", nm, wr_q.size(), exp_wr_q.size()); end
      else for (int i = 0; i < wr_q.size(); i++) begin
         n_cmp++;
         if (wr_q[i] !== exp_wr_q[i]) begin n_bad++; $display("FAIL %s_wr%0d: got %h want %h", nm, i, wr_q[i], exp_wr_q[i]); end
      end
      n_cmp++;
      if ({bus.cpu_reset_n, bus.done, bus.err} !== exp_flags) begin n_bad++; $display("FAIL %s_flags: got %b want %b", nm, {bus.cpu_reset_n, bus.done, bus.err}, exp_flags); end
   endtask

   task automatic test_garbage_and_len();
      frame_q = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h00, 8'h00, 8'h00};
      wr_q.delete();
      drive_frame(1'b1);
      n_cmp++;
      if (wr_q.size() !== 0) begin n_bad++; $display("FAIL empty_frame_wr_count: got %0d want 0", wr_q.size()); end
      n_cmp++;
      if ({bus.cpu_reset_n, bus.done, bus.err} !== 3'b110) begin n_bad++; $display("FAIL empty_frame_flags: got %b want 110", {bus.cpu_reset_n, bus.done, bus.err}); end
      frame_q = '{8'hA5, 8'h01, 8'h01};
      drive_frame(1'b0);
      n_cmp++;
      if ({bus.cpu_reset_n, bus.done, bus.err} !== 3'b001) begin n_bad++; $display("FAIL len_0101_flags: got %b want 001", {bus.cpu_reset_n, bus.done, bus.err}); end
      frame_q = '{8'hA5, 8'(TB_MAX + 1), 8'h00};
      drive_frame(1'b0);
      n_cmp++;
      if ({bus.cpu_reset_n, bus.done, bus.err} !== 3'b001) begin n_bad++; $display("FAIL len_max_plus1_flags: got %b want 001", {bus.cpu_reset_n, bus.done, bus.err}); end
   endtask

   task automatic test_timeout();
      int k;
      frame_q = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h05, 8'h10};
      wr_q.delete();
      drive_frame(1'b0);
      k = 0;
      while (bus.err !== 1'b1 && k < 40) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (k !== TB_TMO) begin n_bad++; $display("FAIL timeout_cycles: got %0d want %0d", k, TB_TMO); end
      n_cmp++;
      if (wr_q.size() !== 0) begin n_bad++; $display("FAIL timeout_wr_count: got %0d want 0", wr_q.size()); end
   endtask

   task automatic test_reload_from_run();
      make_frame(1, 1'b0);
      drive_frame(1'b1);
      n_cmp++;
      if ({bus.cpu_reset_n, bus.done} !== 2'b11) begin n_bad++; $display("FAIL reload_pre_run: got %b want 11", {bus.cpu_reset_n, bus.done}); end
      frame_q = '{8'h5A, 8'hA5};
      drive_frame(1'b0);
      n_cmp++;
      if ({bus.cpu_reset_n, bus.done, bus.err} !== 3'b000) begin n_bad++; $display("FAIL reload_release: got %b want 000", {bus.cpu_reset_n, bus.done, bus.err}); end
      make_frame(2, 1'b0);
      void'(frame_q.pop_front());
      wr_q.delete();
      drive_frame(1'b1);
      n_cmp++;
      if (wr_q !== exp_wr_q) begin n_bad++; $display("FAIL reload_writes: got %0d writes want %0d", wr_q.size(), exp_wr_q.size()); end
      n_cmp++;
      if ({bus.cpu_reset_n, bus.done, bus.err} !== 3'b110) begin n_bad++; $display("FAIL reload_flags: got %b want 110", {bus.cpu_reset_n, bus.done, bus.err}); end
   endtask

   task automatic test_back_to_back();
      int n;
      n = $urandom_range(3, TB_MAX);
      make_frame(n, 1'b0);
      wr_q.delete();
      stall_cnt = 0;
      drive_frame(1'b0);
      n_cmp++;
      if (stall_cnt !== n) begin n_bad++; $display("FAIL b2b_stalls: got %0d want %0d", stall_cnt, n); end
      n_cmp++;
      if (wr_q.size() !== n) begin n_bad++; $display("FAIL b2b_wr_count: got %0d want %0d", wr_q.size(), n); end
      else for (int i = 0; i < n; i++) begin
         n_cmp++;
         if (wr_q[i] !== exp_wr_q[i]) begin n_bad++; $display("FAIL b2b_wr%0d: got %h want %h", i, wr_q[i], exp_wr_q[i]); end
      end
      n_cmp++;
      if ({bus.cpu_reset_n, bus.done, bus.err} !== 3'b110) begin n_bad++; $display("FAIL b2b_flags: got %b want 110", {bus.cpu_reset_n, bus.done, bus.err}); end
   endtask

   task automatic test_random_frames();
      int  n;
      bit  bad;
      for (int f = 0; f < 8; f++) begin
         n   = (f == 0) ? TB_MAX : $urandom_range(1, TB_MAX);
         bad = ($urandom_range(0, 2) == 0);
         make_frame(n, bad);
         wr_q.delete();
         drive_frame(1'b1);
         n_cmp++;
         if (wr_q.size() !== n) begin n_bad++; $display("FAIL rand%0d_wr_count: got %0d want %0d", f, wr_q.size(), n); end
         else for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (wr_q[i] !== exp_wr_q[i]) begin n_bad++; $display("FAIL rand%0d_wr%0d: got %h want %h", f, i, wr_q[i], exp_wr_q[i]); end
         end
         n_cmp++;
         if ({bus.cpu_reset_n, bus.done, bus.err} !== (bad ? 3'b001 : 3'b110)) begin
            n_bad++; $display("FAIL rand%0d_flags: got %b want %b", f, {bus.cpu_reset_n, bus.done, bus.err}, bad ? 3'b001 : 3'b110);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      make_frame(3, 1'b0);
      frame_q = frame_q[0:7];
      drive_frame(1'b0);
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({bus.tb_addr, bus.tb_inst, bus.tb_we, bus.rx_ready} !== {BASE, 32'h0, 1'b0, 1'b1}) begin
         n_bad++; $display("FAIL midreset_bus: got %h/%h/%b/%b want %h/0/0/1", bus.tb_addr, bus.tb_inst, bus.tb_we, bus.rx_ready, BASE);
      end
      n_cmp++;
      if ({bus.cpu_reset_n, bus.done, bus.err} !== 3'b000) begin n_bad++; $display("FAIL midreset_flags: got %b want 000", {bus.cpu_reset_n, bus.done, bus.err}); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      make_frame(2, 1'b0);
      wr_q.delete();
      drive_frame(1'b1);
      n_cmp++;
      if (wr_q !== exp_wr_q) begin n_bad++; $display("FAIL midreset_reload_writes: got %0d writes want %0d", wr_q.size(), exp_wr_q.size()); end
      n_cmp++;
      if ({bus.cpu_reset_n, bus.done, bus.err} !== 3'b110) begin n_bad++; $display("FAIL midreset_reload_flags: got %b want 110", {bus.cpu_reset_n, bus.done, bus.err}); end
   endtask

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      test_reset();
      test_good_frame(8'hB2, 3'b110, "good");
      test_good_frame(8'hB3, 3'b001, "badcs");
      test_good_frame(8'hB2, 3'b110, "recover");
      test_garbage_and_len();
      test_timeout();
      test_reload_from_run();
      test_back_to_back();
      test_random_frames();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
